snn_xor_driver: RTL and testbench

- Initiator-side controller for the 2-2-1 XOR spiking network: the network consumes start/inputs and returns done/spike_count; this block drives that interface.
- Accepts single-pattern or full-sweep requests on a valid/ready port and issues one run per pattern.
- Holds the network inputs stable for the whole run and captures spike_count on done.
- Classifies the count against a threshold, compares the result with the XOR truth, and returns one response per pattern, with a timeout guard and a mismatch counter.

---
 rtl/snn_xor_driver.sv | 141 ++++++++++++++
 tb/tb_snn_xor_driver.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snn_xor_driver.sv
// Initiator-side controller for the 2-2-1 XOR spiking network: issues one run per
// pattern, captures the spike count on done, classifies it and reports against XOR.
module snn_xor_driver #(
    parameter logic [7:0] SPIKE_THRESHOLD = 8'd6,
    parameter int         TIMEOUT_CYCLES  = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_inputs,
    input  logic       req_sweep,
    output logic       nn_start,
    output logic [1:0] nn_inputs,
    input  logic       nn_done,
    input  logic [7:0] nn_spike_count,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [1:0] rsp_inputs,
    output logic [7:0] rsp_spike_count,
    output logic       rsp_class,
    output logic       rsp_expected,
    output logic       rsp_timeout,
    output logic       rsp_last,
    output logic [7:0] mismatch_count,
    output logic       busy,
    output logic [1:0] dbg_state
);
    // Handshakes: a transfer happens on a rising clk edge where valid && ready;
    // the initiator holds valid and its payload stable until that edge.

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESPOND = 2'd3} state_t;

    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

    state_t     state_q;
    logic       sweep_q;
    logic [7:0] tmo_q, tmo_d;
    logic       req_ready_q, busy_q, nn_start_q;
    logic [1:0] nn_inputs_q, rsp_inputs_q;
    logic       rsp_valid_q, rsp_class_q, rsp_expected_q, rsp_timeout_q, rsp_last_q;
    logic [7:0] rsp_spike_count_q, mismatch_q;
    logic       rsp_bad;

    always_comb begin
        tmo_d   = tmo_q + 8'd1;
        rsp_bad = rsp_timeout_q || (rsp_class_q != rsp_expected_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q           <= IDLE;
            sweep_q           <= 1'b0;
            tmo_q             <= 8'd0;
            req_ready_q       <= 1'b1;
            busy_q            <= 1'b0;
            nn_start_q        <= 1'b0;
            nn_inputs_q       <= 2'b00;
            rsp_valid_q       <= 1'b0;
            rsp_inputs_q      <= 2'b00;
            rsp_spike_count_q <= 8'd0;
            rsp_class_q       <= 1'b0;
            rsp_expected_q    <= 1'b0;
            rsp_timeout_q     <= 1'b0;
            rsp_last_q        <= 1'b0;
            mismatch_q        <= 8'd0;
        end else begin
            nn_start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        sweep_q     <= req_sweep;
                        nn_inputs_q <= req_sweep ? 2'b00 : req_inputs;
                        nn_start_q  <= 1'b1;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    // done may still be high from the previous run here; it is ignored.
                    tmo_q   <= 8'd0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (nn_done || (tmo_d == TMO_LIMIT)) begin
                        rsp_valid_q    <= 1'b1;
                        rsp_inputs_q   <= nn_inputs_q;
                        rsp_expected_q <= nn_inputs_q[0] ^ nn_inputs_q[1];
                        rsp_last_q     <= !sweep_q || (nn_inputs_q == 2'b11);
                        state_q        <= RESPOND;
                        if (nn_done) begin
                            rsp_spike_count_q <= nn_spike_count;
                            rsp_class_q       <= (nn_spike_count >= SPIKE_THRESHOLD);
                            rsp_timeout_q     <= 1'b0;
                        end else begin
                            rsp_spike_count_q <= 8'd0;
                            rsp_class_q       <= 1'b0;
                            rsp_timeout_q     <= 1'b1;
                        end
                    end else begin
                        tmo_q <= tmo_d;
                    end
                end
                RESPOND: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        if (rsp_bad && (mismatch_q != 8'hFF)) begin
                            mismatch_q <= mismatch_q + 8'd1;
                        end
                        if (sweep_q && (nn_inputs_q != 2'b11)) begin
                            nn_inputs_q <= nn_inputs_q + 2'd1;
                            nn_start_q  <= 1'b1;
                            state_q     <= ISSUE;
                        end else begin
                            req_ready_q <= 1'b1;
                            busy_q      <= 1'b0;
                            state_q     <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready       = req_ready_q;
    assign busy            = busy_q;
    assign nn_start        = nn_start_q;
    assign nn_inputs       = nn_inputs_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_inputs      = rsp_inputs_q;
    assign rsp_spike_count = rsp_spike_count_q;
    assign rsp_class       = rsp_class_q;
    assign rsp_expected    = rsp_expected_q;
    assign rsp_timeout     = rsp_timeout_q;
    assign rsp_last        = rsp_last_q;
    assign mismatch_count  = mismatch_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_snn_xor_driver.sv
// Bench for snn_xor_driver: behavioural network responder, response model with an
// expected queue, per-cycle compare process and directed scenarios.
module tb_snn_xor_driver;
    localparam logic [7:0] TH  = 8'd6;
    localparam int         TMO = 64;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_inputs = 2'b00;
    logic       req_sweep = 1'b0;
    logic       nn_start;
    logic [1:0] nn_inputs;
    logic       nn_done = 1'b0;
    logic [7:0] nn_spike_count = 8'd0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic [1:0] rsp_inputs;
    logic [7:0] rsp_spike_count;
    logic       rsp_class, rsp_expected, rsp_timeout, rsp_last;
    logic [7:0] mismatch_count;
    logic       busy;
    logic [1:0] dbg_state;

    snn_xor_driver #(.SPIKE_THRESHOLD(TH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_inputs(req_inputs), .req_sweep(req_sweep),
        .nn_start(nn_start), .nn_inputs(nn_inputs), .nn_done(nn_done), .nn_spike_count(nn_spike_count),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_inputs(rsp_inputs),
        .rsp_spike_count(rsp_spike_count), .rsp_class(rsp_class), .rsp_expected(rsp_expected),
        .rsp_timeout(rsp_timeout), .rsp_last(rsp_last), .mismatch_count(mismatch_count),
        .busy(busy), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    // ---------------- network responder ----------------
    typedef struct packed {
        logic       nodone;
        logic [7:0] lat;
        logic [7:0] count;
    } run_t;
    run_t run_q[$];

    logic       nw_running = 1'b0;
    logic [7:0] nw_cnt = 8'd0;
    logic [7:0] nw_val = 8'd0;

    always @(posedge clk) begin
        run_t cur;
        if (nn_start) begin
            nn_done <= 1'b0;
            if (run_q.size() > 0) begin
                cur = run_q.pop_front();
                nw_running <= !cur.nodone;
                nw_cnt     <= cur.lat;
                nw_val     <= cur.count;
            end else begin
                nw_running <= 1'b0;
            end
        end else if (nw_running) begin
            if (nw_cnt <= 8'd1) begin
                nn_done        <= 1'b1;
                nn_spike_count <= nw_val;
                nw_running     <= 1'b0;
            end else begin
                nw_cnt <= nw_cnt - 8'd1;
            end
        end
    end

    // ---------------- response model / scoreboard ----------------
    typedef struct packed {
        logic [1:0] inputs;
        logic [7:0] count;
        logic       timeout;
        logic       last;
        logic [7:0] lat;
    } exp_t;
    exp_t exp_q[$];

    logic [7:0] mism_m = 8'd0;
    int         cyc = 0;
    int         start_cyc = 0;
    int         exp_start_cyc = -1;
    int         n_start = 0;
    logic       prev_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic cls;
        cyc++;
        if (reset) begin
            prev_valid    = 1'b0;
            exp_start_cyc = -1;
        end else begin
            check("req_ready_vs_busy", {31'd0, req_ready}, {31'd0, !busy});
            if (exp_start_cyc == cyc) begin
                check("start_after_accept", {31'd0, nn_start}, 32'd1);
                exp_start_cyc = -1;
            end
            if (nn_start) begin
                n_start++;
                start_cyc = cyc;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL spurious_start: actual=nn_start=1 required=no start pending");
                end
            end
            if (busy && exp_q.size() > 0)
                check("nn_inputs_held", {30'd0, nn_inputs}, {30'd0, exp_q[0].inputs});
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_rsp: actual=rsp_valid=1 required=no response pending");
                end else begin
                    e   = exp_q[0];
                    cls = !e.timeout && (e.count >= TH);
                    check("rsp_fields",
                          {19'd0, rsp_inputs, rsp_spike_count, rsp_class, rsp_expected, rsp_timeout, rsp_last},
                          {19'd0, e.inputs, e.count, cls, e.inputs[0] ^ e.inputs[1], e.timeout, e.last});
                    check("mismatch_count", {24'd0, mismatch_count}, {24'd0, mism_m});
                    if (!prev_valid)
                        check("rsp_latency", cyc - start_cyc, {24'd0, e.lat});
                    if (rsp_ready) begin
                        if (e.timeout || (cls != (e.inputs[0] ^ e.inputs[1])))
                            mism_m = (mism_m == 8'hFF) ? 8'hFF : mism_m + 8'd1;
                        void'(exp_q.pop_front());
                        if (!e.last) exp_start_cyc = cyc + 1;
                    end
                end
            end
            prev_valid = rsp_valid && !rsp_ready;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic plan(input logic [1:0] in, input logic [7:0] count, input logic [7:0] lat,
                        input logic nodone, input logic last);
        run_t r;
        exp_t e;
        r.nodone = nodone; r.lat = lat; r.count = count;
        run_q.push_back(r);
        e.inputs  = in;
        e.count   = nodone ? 8'd0 : count;
        e.timeout = nodone;
        e.last    = last;
        e.lat     = nodone ? 8'(TMO + 1) : lat + 8'd2;
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic sw, input logic [1:0] in);
        int guard = 0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_sweep = sw; req_inputs = in;
        do begin
            @(negedge clk);
            guard++;
        end while (!req_ready && guard < 200);
        if (!req_ready) begin
            n_fail++;
            $display("FAIL req_handshake: actual=req_ready=0 required=1 within 200 cycles");
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic single(input logic [1:0] in, input logic [7:0] count, input logic [7:0] lat,
                          input logic nodone);
        plan(in, count, lat, nodone, 1'b1);
        issue(1'b0, in);
    endtask

    task automatic sweep(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2,
                         input logic [7:0] c3, input logic [7:0] lat);
        plan(2'd0, c0, lat, 1'b0, 1'b0);
        plan(2'd1, c1, lat, 1'b0, 1'b0);
        plan(2'd2, c2, lat, 1'b0, 1'b0);
        plan(2'd3, c3, lat, 1'b0, 1'b1);
        issue(1'b1, 2'b11);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(exp_q.size() == 0 && !busy) && n < budget);
        n_checks++;
        if (exp_q.size() != 0 || busy) begin
            n_fail++;
            $display("FAIL wait_done: actual=%0d responses pending required=0 within %0d cycles",
                     exp_q.size(), budget);
            exp_q.delete();
        end
    endtask

    task automatic check_reset_vals(input string name);
        check(name, {2'd0, nn_start, nn_inputs, rsp_valid, rsp_inputs, rsp_spike_count, rsp_class,
                     rsp_expected, rsp_timeout, rsp_last, mismatch_count, busy, req_ready, dbg_state},
              {2'd0, 28'h0000001, 2'b00});
    endtask

    // ---------------- directed scenarios ----------------
    int s;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset_values");
        reset = 1'b0;

        // single 01, responder count 9 after 12 cycles
        s = n_start;
        single(2'b01, 8'd9, 8'd12, 1'b0);
        wait_done(100);
        check("t1_starts", n_start - s, 32'd1);
        check("t1_mismatch", {24'd0, mismatch_count}, 32'd0);

        // sweep, counts {0,8,8,0}: all correct
        s = n_start;
        sweep(8'd0, 8'd8, 8'd8, 8'd0, 8'd4);
        wait_done(200);
        check("t2_starts", n_start - s, 32'd4);
        check("t2_mismatch", {24'd0, mismatch_count}, 32'd0);

        // sweep, counts {7,2,8,0}: classes {1,0,1,0}, two wrong
        sweep(8'd7, 8'd2, 8'd8, 8'd0, 8'd3);
        wait_done(200);
        check("t3_mismatch", {24'd0, mismatch_count}, 32'd2);

        // responder never finishes: timeout
        single(2'b10, 8'd0, 8'd1, 1'b1);
        wait_done(200);
        check("t4_timeout_mismatch", {24'd0, mismatch_count}, 32'd3);

        // run that leaves done high, then a slow run must not see the stale done
        single(2'b00, 8'd9, 8'd3, 1'b0);
        wait_done(100);
        check("t4_done_left_high", {31'd0, nn_done}, 32'd1);
        single(2'b11, 8'd3, 8'd12, 1'b0);
        wait_done(100);
        check("t4_stale_mismatch", {24'd0, mismatch_count}, 32'd4);

        // backpressure during a sweep, plus req_valid pulsed while busy
        rsp_ready = 1'b0;
        s = n_start;
        sweep(8'd1, 8'd9, 8'd9, 8'd1, 8'd2);
        for (int i = 0; i < 100 && !rsp_valid; i++) @(negedge clk);
        check("t5_rsp_seen", {31'd0, rsp_valid}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b1; req_sweep = 1'b0; req_inputs = 2'b10;
        repeat (5) @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (15) @(negedge clk);
        check("t5_no_start_held", n_start - s, 32'd1);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        wait_done(200);
        check("t5_starts", n_start - s, 32'd4);
        check("t5_mismatch", {24'd0, mismatch_count}, 32'd4);

        // reset asserted while waiting on the network
        plan(2'b01, 8'd9, 8'd30, 1'b0, 1'b1);
        issue(1'b0, 2'b01);
        repeat (5) @(posedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        check_reset_vals("reset_mid_run");
        exp_q.delete();
        mism_m = 8'd0;
        @(negedge clk);
        reset = 1'b0;
        wait_done(10);

        // saturation: 256 wrong single runs (00 classified 1)
        for (int i = 0; i < 256; i++) begin
            single(2'b00, 8'd9, 8'd1, 1'b0);
            wait_done(50);
        end
        check("sat_mismatch", {24'd0, mismatch_count}, 32'd255);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
